// File: rtl/sha256_bus_master.sv
// sha256_bus_master: streams one padded block into sha256_core and streams the digest out.
// Build option SHA_MASTER_IDCHECK_EN inserts a core ID check (addr 64 == 8'h07) after reset.
module sha256_bus_master #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       o_core_rst_n,
    output logic [6:0] o_core_addr,
    output logic [7:0] o_core_wdata,
    output logic       o_core_we,
    input  logic [7:0] i_core_rdata,
    input  logic       i_core_irq,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [2:0] {
        IDLE, CRST, IDCHK, LOAD, START, WAIT, READ, ERR
    } state_e;

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [6:0] ADDR_ID  = 7'd64;
    localparam logic [6:0] ADDR_ST  = 7'd65;
    localparam logic [6:0] ADDR_H0  = 7'd101;

    state_e     state_q;
    logic       s_ready_q;
    logic [7:0] m_data_q;
    logic       m_valid_q;
    logic       m_last_q;
    logic       crst_n_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;
    logic       we_q;
    logic       busy_q;
    logic       err_q;
    logic [5:0] i_q;
    logic [4:0] j_q;
    logic [7:0] cnt_q;

    logic in_hs;
    logic out_hs;

    assign in_hs  = s_valid & s_ready_q;
    assign out_hs = m_valid_q & m_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            crst_n_q  <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            i_q       <= 6'd0;
            j_q       <= 5'd0;
            cnt_q     <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    crst_n_q <= 1'b1;
                    we_q     <= 1'b0;
                    if (s_valid && !err_q) begin
                        state_q  <= CRST;
                        crst_n_q <= 1'b0;
                        cnt_q    <= 8'd0;
                        busy_q   <= 1'b1;
                    end
                end
                CRST: begin
                    if (cnt_q == RST_LAST) begin
                        crst_n_q <= 1'b1;
                        i_q      <= 6'd0;
`ifdef SHA_MASTER_IDCHECK_EN
                        state_q  <= IDCHK;
                        addr_q   <= ADDR_ID;
                        cnt_q    <= 8'd0;
`else
                        state_q   <= LOAD;
                        s_ready_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                IDCHK: begin
                    // first cycle lets the core's read mux settle on the ID address
                    if (cnt_q == 8'd0) begin
                        cnt_q <= 8'd1;
                    end else if (i_core_rdata == 8'h07) begin
                        state_q   <= LOAD;
                        s_ready_q <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    we_q <= 1'b0;
                    if (in_hs) begin
                        we_q    <= 1'b1;
                        addr_q  <= 7'd63 - {1'b0, i_q};
                        wdata_q <= s_data;
                        if (i_q == 6'd63) begin
                            s_ready_q <= 1'b0;
                            state_q   <= START;
                        end else begin
                            i_q <= i_q + 6'd1;
                        end
                    end
                end
                START: begin
                    we_q    <= 1'b1;
                    addr_q  <= ADDR_ST;
                    wdata_q <= 8'h01;
                    cnt_q   <= 8'd0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    we_q   <= 1'b0;
                    addr_q <= ADDR_ST;
                    if (i_core_irq) begin
                        state_q <= READ;
                        j_q     <= 5'd0;
                        addr_q  <= ADDR_H0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                READ: begin
                    if (!m_valid_q) begin
                        m_data_q  <= i_core_rdata;
                        m_valid_q <= 1'b1;
                        m_last_q  <= (j_q == 5'd31);
                    end else if (out_hs) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        if (j_q == 5'd31) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            j_q    <= j_q + 5'd1;
                            addr_q <= 7'd100 - {2'b00, j_q};
                        end
                    end
                end
                ERR: begin
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    we_q      <= 1'b0;
                    crst_n_q  <= 1'b1;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign o_core_rst_n = crst_n_q;
    assign o_core_addr  = addr_q;
    assign o_core_wdata = wdata_q;
    assign o_core_we    = we_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

endmodule
